// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and row-major state <-> column helpers.
package aes_pkg;

  localparam int unsigned NR         = 10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  XTIME_POLY = 8'h1b;

  typedef enum logic {
    ARK_IDLE   = 1'b0,
    ARK_EXPAND = 1'b1
  } ark_state_e;

  // MSB position of byte (row r, column c) in a row-major 128-bit state.
  function automatic int byte_msb(input int r, input int c);
    return 127 - 8 * (4 * r + c);
  endfunction

  function automatic logic [31:0] state_col(input logic [127:0] s, input int c);
    logic [31:0] w;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      w[31 - 8 * r -: 8] = s[byte_msb(r, c) -: 8];
    end
    return w;
  endfunction

  function automatic logic [127:0] col_insert(input logic [127:0] s, input int c,
                                              input logic [31:0] w);
    logic [127:0] o;
    o = s;
    for (int r = 0; r < 4; r++) begin
      o[byte_msb(r, c) -: 8] = w[31 - 8 * r -: 8];
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion, one step per accepted state.
//   state      | meaning
//   ARK_IDLE   | waiting for pi_enable; round key rk_q is ready to apply
//   ARK_EXPAND | one cycle computing the next round key; enables are dropped
module add_round_key_stage
  import aes_pkg::*;
(
  input  logic         pi_clk,
  input  logic         pi_rst,
  input  logic         pi_key_load,
  input  logic [127:0] pi_key,
  input  logic         pi_enable,
  input  logic [127:0] pi_in,
  output logic         po_add_round_key_done,
  output logic [127:0] po_out,
  output logic [3:0]   po_round,
  output logic         po_busy,
  output logic         po_key_valid,
  output logic         po_overrun
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ark_state_e   state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] out_q, out_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic         key_valid_q, key_valid_d;
  logic         overrun_q, overrun_d;
  logic         done_q, done_d;

  logic         accept;
  logic [31:0]  w0, w1, w2, w3, rot_w3, sub_w3, t;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] rk_next;

  // Key load wins over any enable presented in the same cycle.
  assign accept = pi_enable && key_valid_q && (state_q == ARK_IDLE) && !pi_key_load;

  assign w0     = state_col(rk_q, 0);
  assign w1     = state_col(rk_q, 1);
  assign w2     = state_col(rk_q, 2);
  assign w3     = state_col(rk_q, 3);
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .byte_i (rot_w3[8*g +: 8]),
      .byte_o (sub_w3[8*g +: 8])
    );
  end

  assign t    = sub_w3 ^ {rcon_q, 24'h0};
  assign w0_n = w0 ^ t;
  assign w1_n = w1 ^ w0_n;
  assign w2_n = w2 ^ w1_n;
  assign w3_n = w3 ^ w2_n;

  always_comb begin
    rk_next = '0;
    rk_next = col_insert(rk_next, 0, w0_n);
    rk_next = col_insert(rk_next, 1, w1_n);
    rk_next = col_insert(rk_next, 2, w2_n);
    rk_next = col_insert(rk_next, 3, w3_n);
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      state_q <= ARK_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pi_key_load) begin
      state_d = ARK_IDLE;
    end else begin
      case (state_q)
        ARK_IDLE:   if (accept && (round_q != LAST_ROUND)) state_d = ARK_EXPAND;
        ARK_EXPAND: state_d = ARK_IDLE;
        default:    state_d = ARK_IDLE;
      endcase
    end
  end

  assign po_busy = (state_q == ARK_EXPAND);

  always_comb begin
    rk_d        = rk_q;
    out_d       = out_q;
    rcon_d      = rcon_q;
    round_d     = round_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
    if (pi_key_load) begin
      rk_d        = pi_key;
      rcon_d      = RCON_INIT;
      round_d     = '0;
      key_valid_d = 1'b1;
      overrun_d   = 1'b0;
    end else begin
      if (accept) begin
        out_d  = pi_in ^ rk_q;
        done_d = 1'b1;
        if (round_q == LAST_ROUND) key_valid_d = 1'b0;
      end else if (pi_enable) begin
        overrun_d = 1'b1;
      end
      if (state_q == ARK_EXPAND) begin
        rk_d    = rk_next;
        rcon_d  = xtime(rcon_q);
        round_d = round_q + 4'd1;
      end
    end
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      rk_q        <= '0;
      out_q       <= '0;
      rcon_q      <= RCON_INIT;
      round_q     <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rk_q        <= rk_d;
      out_q       <= out_d;
      rcon_q      <= rcon_d;
      round_q     <= round_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
    end
  end

  assign po_add_round_key_done = done_q;
  assign po_out                = out_q;
  assign po_round              = round_q;
  assign po_key_valid          = key_valid_q;
  assign po_overrun            = overrun_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage using FIPS-197 key schedule vectors.
module tb_add_round_key_stage;

  logic         pi_clk = 1'b0;
  logic         pi_rst;
  logic         pi_key_load;
  logic [127:0] pi_key;
  logic         pi_enable;
  logic [127:0] pi_in;
  logic         po_add_round_key_done;
  logic [127:0] po_out;
  logic [3:0]   po_round;
  logic         po_busy;
  logic         po_key_valid;
  logic         po_overrun;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY0  = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
  localparam logic [127:0] KEY1  = 128'ha088232a_fa54a36c_fe2c3976_17b13905;
  localparam logic [127:0] KEY10 = 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6;
  localparam logic [127:0] KEYB  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] ONES  = {128{1'b1}};

  add_round_key_stage dut (
    .pi_clk                (pi_clk),
    .pi_rst                (pi_rst),
    .pi_key_load           (pi_key_load),
    .pi_key                (pi_key),
    .pi_enable             (pi_enable),
    .pi_in                 (pi_in),
    .po_add_round_key_done (po_add_round_key_done),
    .po_out                (po_out),
    .po_round              (po_round),
    .po_busy               (po_busy),
    .po_key_valid          (po_key_valid),
    .po_overrun            (po_overrun)
  );

  always #5 pi_clk = ~pi_clk;

  task automatic step();
    @(posedge pi_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    pi_rst      = 1'b1;
    pi_key_load = 1'b0;
    pi_key      = '0;
    pi_enable   = 1'b0;
    pi_in       = '0;
    step();
    step();
    pi_rst = 1'b0;
    check("rst_out",       po_out, '0);
    check("rst_done",      128'(po_add_round_key_done), 128'd0);
    check("rst_round",     128'(po_round), 128'd0);
    check("rst_busy",      128'(po_busy), 128'd0);
    check("rst_key_valid", 128'(po_key_valid), 128'd0);
    check("rst_overrun",   128'(po_overrun), 128'd0);

    // enable with no key loaded is dropped
    pi_enable = 1'b1;
    pi_in     = ONES;
    step();
    pi_enable = 1'b0;
    check("nokey_done",    128'(po_add_round_key_done), 128'd0);
    check("nokey_out",     po_out, '0);
    check("nokey_overrun", 128'(po_overrun), 128'd1);

    pi_key_load = 1'b1;
    pi_key      = KEY0;
    step();
    pi_key_load = 1'b0;
    check("load_key_valid", 128'(po_key_valid), 128'd1);
    check("load_overrun",   128'(po_overrun), 128'd0);
    check("load_round",     128'(po_round), 128'd0);

    // enable 1 (round key 0)
    pi_enable = 1'b1;
    pi_in     = '0;
    step();
    pi_enable = 1'b0;
    check("e1_done",  128'(po_add_round_key_done), 128'd1);
    check("e1_out",   po_out, KEY0);
    check("e1_busy",  128'(po_busy), 128'd1);
    check("e1_round", 128'(po_round), 128'd0);
    step();
    check("e1_done_off", 128'(po_add_round_key_done), 128'd0);
    check("e1_busy_off", 128'(po_busy), 128'd0);
    check("e1_round1",   128'(po_round), 128'd1);
    check("e1_hold",     po_out, KEY0);

    // enable 2 (round key 1)
    pi_enable = 1'b1;
    step();
    pi_enable = 1'b0;
    check("e2_out",  po_out, KEY1);
    check("e2_done", 128'(po_add_round_key_done), 128'd1);
    step();

    // enables 3..11
    for (int i = 3; i <= 11; i++) begin
      pi_enable = 1'b1;
      step();
      pi_enable = 1'b0;
      check($sformatf("e%0d_done", i), 128'(po_add_round_key_done), 128'd1);
      if (i == 11) begin
        check("e11_out",       po_out, KEY10);
        check("e11_key_valid", 128'(po_key_valid), 128'd0);
        check("e11_round",     128'(po_round), 128'd10);
        check("e11_busy",      128'(po_busy), 128'd0);
        check("e11_overrun",   128'(po_overrun), 128'd0);
      end
      step();
    end
    check("final_round", 128'(po_round), 128'd10);

    // enable 12 dropped after the last round
    pi_enable = 1'b1;
    pi_in     = ONES;
    step();
    pi_enable = 1'b0;
    check("e12_done",    128'(po_add_round_key_done), 128'd0);
    check("e12_overrun", 128'(po_overrun), 128'd1);
    check("e12_out",     po_out, KEY10);

    // enable during EXPAND is dropped, schedule unaffected
    pi_key_load = 1'b1;
    pi_key      = KEY0;
    step();
    pi_key_load = 1'b0;
    pi_enable   = 1'b1;
    pi_in       = '0;
    step();
    check("x_busy", 128'(po_busy), 128'd1);
    step();
    pi_enable = 1'b0;
    check("x_drop_done",    128'(po_add_round_key_done), 128'd0);
    check("x_drop_overrun", 128'(po_overrun), 128'd1);
    check("x_drop_out",     po_out, KEY0);
    check("x_drop_round",   128'(po_round), 128'd1);
    pi_enable = 1'b1;
    step();
    pi_enable = 1'b0;
    check("x_next_out",  po_out, KEY1);
    check("x_next_done", 128'(po_add_round_key_done), 128'd1);

    // key load during EXPAND with simultaneous enable
    pi_key_load = 1'b1;
    pi_key      = KEYB;
    pi_enable   = 1'b1;
    pi_in       = ONES;
    step();
    pi_key_load = 1'b0;
    pi_enable   = 1'b0;
    check("kl_round",     128'(po_round), 128'd0);
    check("kl_done",      128'(po_add_round_key_done), 128'd0);
    check("kl_overrun",   128'(po_overrun), 128'd0);
    check("kl_busy",      128'(po_busy), 128'd0);
    check("kl_key_valid", 128'(po_key_valid), 128'd1);
    check("kl_out_hold",  po_out, KEY1);
    pi_enable = 1'b1;
    pi_in     = ONES;
    step();
    pi_enable = 1'b0;
    check("kl_apply_out",  po_out, ~KEYB);
    check("kl_apply_done", 128'(po_add_round_key_done), 128'd1);

    // reset in the middle of an expansion
    pi_rst = 1'b1;
    step();
    pi_rst = 1'b0;
    check("mrst_out",       po_out, '0);
    check("mrst_round",     128'(po_round), 128'd0);
    check("mrst_busy",      128'(po_busy), 128'd0);
    check("mrst_key_valid", 128'(po_key_valid), 128'd0);
    check("mrst_done",      128'(po_add_round_key_done), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
